// File: rtl/conv1_acc_drain.sv
// Counts heap accumulate beats, snapshots 64 channel sums per pixel and serializes them (optional ReLU).
// First word two cycles after the last beat; out_rdy low holds the word, and halt stalls beats if the next pixel would finish mid-drain.
module conv1_acc_drain #(
   parameter int CHN       = 64,
   parameter int DW        = 16,
   parameter int ACC_BEATS = 75,
   parameter int AW        = 6,
   parameter int RELU      = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              acc_v_in,
   input  logic [CHN*DW-1:0] acc_data,
   output logic              acc_clr,
   output logic              halt,
   output logic              out_v,
   input  logic              out_rdy,
   output logic [DW-1:0]     out_data,
   output logic [AW-1:0]     out_addr,
   output logic              frame_done,
   output logic [7:0]        frame_cnt,
   output logic              ovf_err
);

   localparam int BW = $clog2(ACC_BEATS);
   localparam logic [BW-1:0] LAST_BEAT = BW'(ACC_BEATS - 1);
   localparam logic [AW-1:0] LAST_CH   = AW'(CHN - 1);

   typedef enum logic [1:0] {RUN, SNAP, DRAIN} state_t;

   state_t            state;
   logic [BW-1:0]     beat_cnt;
   logic [AW-1:0]     idx;
   logic [CHN*DW-1:0] snapshot;
   logic              beat_ok;
   logic              pix_done;
   logic              xfer;
   logic              last_ch;
   logic [DW-1:0]     sum;

   // Halting at the final beat during DRAIN guarantees a pixel never completes mid-drain.
   assign halt     = (state == SNAP) | ((state == DRAIN) & (beat_cnt == LAST_BEAT));
   assign beat_ok  = acc_v_in & ~halt;
   assign pix_done = beat_ok & (beat_cnt == LAST_BEAT);

   assign acc_clr    = (state == SNAP);
   assign out_v      = (state == DRAIN);
   assign out_addr   = idx;
   assign xfer       = out_v & out_rdy;
   assign last_ch    = (idx == LAST_CH);
   assign frame_done = xfer & last_ch;

   assign sum      = snapshot[idx*DW +: DW];
   assign out_data = ((RELU != 0) && sum[DW-1]) ? '0 : sum;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= RUN;
         beat_cnt  <= '0;
         idx       <= '0;
         snapshot  <= '0;
         frame_cnt <= '0;
         ovf_err   <= 1'b0;
      end else begin
         if (beat_ok)
            beat_cnt <= pix_done ? '0 : beat_cnt + 1'b1;
         if (acc_v_in & halt)
            ovf_err <= 1'b1;
         case (state)
            RUN: begin
               if (pix_done)
                  state <= SNAP;
            end
            SNAP: begin
               // Heap shows the last beat's sum one cycle late, so capture here.
               snapshot <= acc_data;
               idx      <= '0;
               state    <= DRAIN;
            end
            DRAIN: begin
               if (xfer) begin
                  idx <= idx + 1'b1;
                  if (last_ch) begin
                     state     <= RUN;
                     frame_cnt <= frame_cnt + 8'd1;
                  end
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_conv1_acc_drain.sv
// Scoreboard bench for conv1_acc_drain: ReLU and pass-through instances share one stimulus stream.
module tb_conv1_acc_drain;

   localparam int CHN = 64;
   localparam int DW  = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              acc_v_in = 1'b0;
   logic [CHN*DW-1:0] acc_data = '0;
   logic              out_rdy = 1'b1;

   logic              acc_clr, halt, out_v, frame_done, ovf_err;
   logic [DW-1:0]     out_data;
   logic [5:0]        out_addr;
   logic [7:0]        frame_cnt;

   logic              acc_clr_p, halt_p, out_v_p, frame_done_p, ovf_err_p;
   logic [DW-1:0]     out_data_p;
   logic [5:0]        out_addr_p;
   logic [7:0]        frame_cnt_p;

   typedef struct {
      logic [5:0]    addr;
      logic [DW-1:0] relu;
      logic [DW-1:0] raw;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   n_xfer = 0;

   conv1_acc_drain #(.RELU(1)) dut (
      .clk(clk), .rst(rst), .acc_v_in(acc_v_in), .acc_data(acc_data),
      .acc_clr(acc_clr), .halt(halt), .out_v(out_v), .out_rdy(out_rdy),
      .out_data(out_data), .out_addr(out_addr), .frame_done(frame_done),
      .frame_cnt(frame_cnt), .ovf_err(ovf_err)
   );

   conv1_acc_drain #(.RELU(0)) dut_pass (
      .clk(clk), .rst(rst), .acc_v_in(acc_v_in), .acc_data(acc_data),
      .acc_clr(acc_clr_p), .halt(halt_p), .out_v(out_v_p), .out_rdy(out_rdy),
      .out_data(out_data_p), .out_addr(out_addr_p), .frame_done(frame_done_p),
      .frame_cnt(frame_cnt_p), .ovf_err(ovf_err_p)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Channel k sum = mul*k + add, wrapped to DW bits.
   task automatic set_pattern(input int mul, input int add);
      for (int k = 0; k < CHN; k++)
         acc_data[k*DW +: DW] = DW'(mul * k + add);
   endtask

   task automatic push_pixel();
      exp_t e;
      for (int k = 0; k < CHN; k++) begin
         e.addr = 6'(k);
         e.raw  = acc_data[k*DW +: DW];
         e.relu = e.raw[DW-1] ? '0 : e.raw;
         sb.push_back(e);
      end
   endtask

   task automatic beats(input int n);
      acc_v_in = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      acc_v_in = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int c = 0;
      do begin
         @(posedge clk);
         #1;
         c++;
      end while ((sb.size() != 0 || out_v) && c < 1000);
      chk(name, c < 1000, 1);
   endtask

   // Monitor: compares every presented word against the scoreboard head.
   always @(negedge clk) begin
      if (rst) begin
         if (out_v) begin
            if (sb.size() == 0) begin
               chk("unexpected_word", 1, 0);
            end else begin
               chk("addr", out_addr, sb[0].addr);
               chk("data_relu", out_data, sb[0].relu);
               chk("pass_v", out_v_p, 1);
               chk("pass_addr", out_addr_p, sb[0].addr);
               chk("data_raw", out_data_p, sb[0].raw);
               if (out_rdy) begin
                  chk("frame_done", frame_done, sb[0].addr == 6'd63);
                  void'(sb.pop_front());
                  n_xfer++;
               end
            end
         end else if (frame_done) begin
            chk("stray_frame_done", 1, 0);
         end
      end
   end

   initial begin
      int c;
      int base;

      // 1: reset with beats toggling
      for (int i = 0; i < 3; i++) begin
         acc_v_in = i[0] ? 1'b0 : 1'b1;
         @(posedge clk);
         #1;
         chk("rst_out_v", out_v, 0);
         chk("rst_acc_clr", acc_clr, 0);
         chk("rst_halt", halt, 0);
         chk("rst_frame_done", frame_done, 0);
         chk("rst_frame_cnt", frame_cnt, 0);
         chk("rst_ovf_err", ovf_err, 0);
      end
      acc_v_in = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // 2: basic pixel, sums 3k, continuous ready
      out_rdy = 1'b1;
      set_pattern(3, 0);
      push_pixel();
      beats(74);
      chk("b74_acc_clr", acc_clr, 0);
      chk("b74_halt", halt, 0);
      beats(1);
      chk("snap_acc_clr", acc_clr, 1);
      chk("snap_halt", halt, 1);
      chk("snap_out_v", out_v, 0);
      @(posedge clk);
      #1;
      chk("first_out_v", out_v, 1);
      chk("first_addr", out_addr, 0);
      chk("snap_clr_gone", acc_clr, 0);
      repeat (63) @(posedge clk);
      #1;
      chk("last_addr", out_addr, 63);
      chk("last_data", out_data, 189);
      chk("last_frame_done", frame_done, 1);
      @(posedge clk);
      #1;
      chk("post_out_v", out_v, 0);
      chk("frame_cnt_1", frame_cnt, 1);

      // 3: alternating backpressure
      set_pattern(7, 100);
      push_pixel();
      beats(75);
      @(posedge clk);
      #1;
      c = 0;
      while (out_v && c < 300) begin
         out_rdy = ~c[0];
         @(posedge clk);
         #1;
         c++;
      end
      out_rdy = 1'b1;
      chk("bp_cycles", c, 127);
      chk("frame_cnt_2", frame_cnt, 2);

      // 4: ReLU boundary values
      set_pattern(1, 0);
      acc_data[5*DW +: DW] = 16'h8003;
      acc_data[6*DW +: DW] = 16'h7FFF;
      acc_data[7*DW +: DW] = 16'hFFFF;
      push_pixel();
      beats(75);
      wait_drain("relu_drain");
      chk("frame_cnt_3", frame_cnt, 3);
      chk("ovf_clean", ovf_err, 0);

      // 5: second pixel arrives while the first is stalled
      out_rdy = 1'b0;
      set_pattern(5, 1);
      push_pixel();
      beats(75);
      @(posedge clk);
      #1;
      chk("ovl_out_v", out_v, 1);
      beats(74);
      chk("ovl_halt", halt, 1);
      chk("ovl_ovf_pre", ovf_err, 0);
      beats(1);
      chk("ovl_ovf", ovf_err, 1);
      chk("ovl_no_snap", acc_clr, 0);
      set_pattern(11, 3);
      push_pixel();
      out_rdy = 1'b1;
      c = 0;
      while (!frame_done && c < 200) begin
         @(posedge clk);
         #1;
         c++;
      end
      chk("ovl_fd_timeout", c < 200, 1);
      chk("ovl_halt_at_fd", halt, 1);
      @(posedge clk);
      #1;
      chk("ovl_halt_drop", halt, 0);
      chk("frame_cnt_4", frame_cnt, 4);
      beats(1);
      chk("ovl_snap", acc_clr, 1);
      wait_drain("ovl_drain");
      chk("frame_cnt_5", frame_cnt, 5);

      // 6: reset mid-drain, then a fresh pixel
      set_pattern(2, 9);
      push_pixel();
      base = n_xfer;
      beats(75);
      c = 0;
      do begin
         @(posedge clk);
         #2;
         c++;
      end while (n_xfer != base + 21 && c < 200);
      chk("mid_timeout", c < 200, 1);
      rst = 1'b0;
      sb.delete();
      @(posedge clk);
      #1;
      chk("mid_out_v", out_v, 0);
      chk("mid_frame_done", frame_done, 0);
      chk("mid_frame_cnt", frame_cnt, 0);
      chk("mid_ovf", ovf_err, 0);
      rst = 1'b1;
      set_pattern(13, 40);
      push_pixel();
      beats(75);
      wait_drain("fresh_drain");
      chk("fresh_frame_cnt", frame_cnt, 1);

      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
